// File: rtl/alu_exec_sequencer.sv
// Multi-cycle ALU execute-stage sequencer.
// Add/sub/and/or/nop finish in one cycle; multiply (shift-add) and divide
// (restoring) iterate one bit per cycle. Results are held until taken.
//
// Handshake: a request is accepted on a rising edge where in_valid & in_ready;
// a result is consumed on a rising edge where out_valid & out_ready. Both
// sides are plain valid/ready: the producer holds valid until it is taken,
// and a valid with no matching ready has no effect.
module alu_exec_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             div_by_zero,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   mcand_q, mplier_q, acc_q;
  logic [WIDTH-1:0]   dvd_q, dvsr_q, rem_q;
  logic [WIDTH-1:0]   result_q;
  logic               dbz_q;

  logic               accept;
  logic               last_iter;
  logic [WIDTH-1:0]   single_res;
  logic [WIDTH-1:0]   acc_next;
  logic [WIDTH-1:0]   rem_shift;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;

  assign accept    = in_valid && (state_q == S_IDLE);
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  // Single-cycle result and one iteration of the multiply/divide datapaths.
  // The divide compares in WIDTH bits: a set remainder MSB means the shifted
  // value is at least 2^WIDTH, which always exceeds the divisor.
  always_comb begin
    single_res = '0;
    case (alu_ctrl)
      OP_ADD:  single_res = op_a + op_b;
      OP_SUB:  single_res = op_a - op_b;
      OP_AND:  single_res = op_a & op_b;
      OP_OR:   single_res = op_a | op_b;
      default: single_res = '0;
    endcase
    acc_next  = acc_q + (mplier_q[0] ? mcand_q : '0);
    rem_shift = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
    rem_ge    = rem_q[WIDTH-1] || (rem_shift >= dvsr_q);
    rem_next  = rem_ge ? (rem_shift - dvsr_q) : rem_shift;
    quo_next  = {dvd_q[WIDTH-2:0], rem_ge};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (alu_ctrl)
            OP_MUL:  state_d = S_MUL;
            OP_DIV:  state_d = (op_b != '0) ? S_DIV : S_DONE;
            default: state_d = S_DONE;
          endcase
        end
      end
      S_MUL:   if (last_iter) state_d = S_DONE;
      S_DIV:   if (last_iter) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand latching, iteration and result capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      dvd_q    <= '0;
      dvsr_q   <= '0;
      rem_q    <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            cnt_q <= '0;
            dbz_q <= 1'b0;
            case (alu_ctrl)
              OP_MUL: begin
                mcand_q  <= op_a;
                mplier_q <= op_b;
                acc_q    <= '0;
              end
              OP_DIV: begin
                if (op_b == '0) begin
                  result_q <= '1;
                  dbz_q    <= 1'b1;
                end else begin
                  dvd_q  <= op_a;
                  dvsr_q <= op_b;
                  rem_q  <= '0;
                end
              end
              default: result_q <= single_res;
            endcase
          end
        end
        S_MUL: begin
          acc_q    <= acc_next;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (last_iter) result_q <= acc_next;
        end
        S_DIV: begin
          rem_q <= rem_next;
          dvd_q <= quo_next;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_iter) result_q <= quo_next;
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign busy        = (state_q == S_MUL) || (state_q == S_DIV);
  assign result      = result_q;
  assign zero        = out_valid && (result_q == '0);
  assign div_by_zero = dbz_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Testbench for alu_exec_sequencer: directed test-plan steps followed by
// randomized operations, checked against an arithmetic reference model.
module tb_alu_exec_sequencer;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   alu_ctrl;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         div_by_zero;
  logic         busy;
  logic [1:0]   dbg_state;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];

  alu_exec_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_ctrl    (alu_ctrl),
    .op_a        (op_a),
    .op_b        (op_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .div_by_zero (div_by_zero),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard comparison helpers
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: plain arithmetic on the operation code
  function automatic logic [W-1:0] model(input logic [2:0] ctrl, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [2*W-1:0] prod;
    prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (ctrl)
      3'd1:    return a + b;
      3'd2:    return a - b;
      3'd3:    return prod[W-1:0];
      3'd4:    return (b == '0) ? {W{1'b1}} : a / b;
      3'd5:    return a & b;
      3'd6:    return a | b;
      default: return '0;
    endcase
  endfunction

  // Driver: issue one request, track latency/busy, check the result, optionally
  // stall the consumer for `hold` cycles, then take the result.
  // With poke set, in_valid is raised for one cycle mid-iteration.
  task automatic run_op(input logic [2:0] ctrl, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, input bit poke);
    int           lat;
    bit           iter;
    logic [W-1:0] exp_r;
    iter  = (ctrl == 3'd3) || (ctrl == 3'd4 && b != '0);
    exp_q.push_back(model(ctrl, a, b));
    chk_bit("in_ready_idle", in_ready, 1'b1);
    in_valid = 1'b1;
    alu_ctrl = ctrl;
    op_a     = a;
    op_b     = b;
    @(negedge clk);
    in_valid = 1'b0;
    op_a     = $urandom;
    op_b     = $urandom;
    alu_ctrl = 3'($urandom_range(0, 7));
    lat = 0;
    while (!out_valid && lat < 100) begin
      chk_bit("busy_iter", busy, iter);
      chk_bit("in_ready_busy", in_ready, 1'b0);
      in_valid = (poke && lat == 5);
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    chk_int("latency", lat, iter ? W : 0);
    exp_r = exp_q.pop_front();
    chk("result", result, exp_r);
    chk_bit("zero", zero, exp_r == '0);
    chk_bit("div_by_zero", div_by_zero, ctrl == 3'd4 && b == '0);
    chk_bit("busy_done", busy, 1'b0);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_result", result, exp_r);
      chk_bit("hold_valid", out_valid, 1'b1);
      chk_bit("hold_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk_bit("post_valid", out_valid, 1'b0);
    chk_bit("post_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    logic [2:0]   rc;
    logic [W-1:0] ra, rb;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    alu_ctrl  = 3'd0;
    op_a      = '0;
    op_b      = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk_bit("rst_in_ready", in_ready, 1'b1);
    chk_bit("rst_out_valid", out_valid, 1'b0);
    chk_bit("rst_busy", busy, 1'b0);
    chk_bit("rst_zero", zero, 1'b0);
    chk_bit("rst_dbz", div_by_zero, 1'b0);
    chk("rst_result", result, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed test-plan steps
    run_op(3'd1, 32'd5, 32'd7, 3, 1'b0);
    run_op(3'd2, 32'd9, 32'd9, 0, 1'b0);
    run_op(3'd2, 32'd3, 32'd4, 0, 1'b0);
    run_op(3'd3, 32'h0001_0003, 32'h0000_0005, 0, 1'b0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'h0000_0002, 0, 1'b0);
    run_op(3'd4, 32'd100, 32'd7, 0, 1'b0);
    run_op(3'd4, 32'd42, 32'd0, 1, 1'b0);

    // Reset in the middle of a multiply aborts it
    in_valid = 1'b1;
    alu_ctrl = 3'd3;
    op_a     = 32'h1234_5678;
    op_b     = 32'h0000_0FFF;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk_bit("mid_mul_busy", busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_bit("abort_out_valid", out_valid, 1'b0);
    chk_bit("abort_busy", busy, 1'b0);
    chk_bit("abort_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    run_op(3'd1, 32'd1, 32'd1, 0, 1'b0);

    run_op(3'd5, 32'h0000_F0F0, 32'h0000_FF00, 0, 1'b0);
    run_op(3'd6, 32'h0000_F0F0, 32'h0000_FF00, 0, 1'b0);
    run_op(3'd7, 32'h0000_F0F0, 32'h0000_FF00, 0, 1'b0);
    run_op(3'd0, 32'hDEAD_BEEF, 32'h0000_0001, 0, 1'b0);

    // Request pulsed during a divide is dropped: no extra result afterwards
    run_op(3'd4, 32'hFFFF_FFFF, 32'h0000_0003, 0, 1'b1);
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_bit("ignored_req_valid", out_valid, 1'b0);
      chk_bit("ignored_req_in_ready", in_ready, 1'b1);
    end
    out_ready = 1'b0;

    // Randomized operations
    for (int i = 0; i < 30; i++) begin
      rc = 3'($urandom_range(0, 7));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_op(rc, ra, rb, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
